regfile_2r1w: RTL and testbench
===============================

# regfile_2r1w

Parametrised register file with two independent read ports (A, B) and one write port. It extends the single-bit, tri-state-read register cell into a full word-addressed array. Reads are registered, with per-byte write enables, same-cycle write-to-read forwarding and an optional hardwired-zero register 0. It sits between instruction decode (read addresses) and writeback (write port) in the datapath.

## Interface

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8
- DEPTH, 32, number of registers; 2..2**ADDR_W
- ADDR_W, 5, address width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- wbe  input  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i]
- re_a  input  1  read enable, port A
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  DATA_W  registered read data, port A
- rvalid_a  output  1  rdata_a updated this cycle
- re_b, raddr_b, rdata_b, rvalid_b  port B, identical to port A

## Operation

- Storage is DEPTH words of DATA_W flops. It is not RAM-inferred, because asynchronous clear is required.
- Write: on a rising clk with we=1 and waddr<DEPTH, each byte i with wbe[i]=1 takes wdata. Bytes with wbe[i]=0 keep their value.
- wbe all zero is a legal no-op write.
- waddr>=DEPTH: the write is ignored and no storage changes.
- Read: on a rising clk with re_x=1, rdata_x loads word raddr_x and rvalid_x=1 for that cycle.
- With re_x=0, rdata_x holds its last value and rvalid_x=0.
- raddr_x>=DEPTH: rdata_x loads 0 and rvalid_x=1.
- Forwarding: a read and a write to the same in-range address in the same cycle (we=1, waddr==raddr_x):
  - rdata_x returns the post-write word, i.e. bytes with wbe=1 from wdata and the other bytes from storage.
  - This holds independently for A and B; both may forward at once.
- Ports A and B may read the same address in the same cycle; both get identical data.
- There is no state machine. Sequential state is the storage array, rdata_a/b and rvalid_a/b.

## Timing

- Reset (rst_n=0, asynchronous, does not wait for clk):
  - All storage words = 0.
  - rdata_a = rdata_b = 0.
  - rvalid_a = rvalid_b = 0.
- Deassertion of rst_n is taken synchronously by the surrounding design. The first write or read can be accepted on the first rising clk with rst_n=1.
- Read latency is 1 cycle: with address presented in cycle N, data and rvalid appear after edge N and are usable in cycle N+1.
- Write latency is 1 cycle: a write at edge N is visible to any non-forwarded read issued in cycle N+1.
- A read in cycle N of an address being written in cycle N returns the new data via forwarding, not the old data.
- Back-to-back reads every cycle are supported; throughput is 1 read per port per cycle plus 1 write per cycle.
- Reset asserted mid-operation: any pending write is lost, storage clears, outputs go to 0 immediately.

## Configuration

- Macro: REGFILE_ZERO_REG_EN
- Defined:
  - Address 0 always reads 0.
  - Writes to address 0 are discarded, and forwarding never applies to address 0.
  - No flops are implemented for word 0.
- Undefined: address 0 is an ordinary register, identical in behaviour to all others.

## Test plan

- Reset check: hold rst_n=0 mid-simulation after writing 0xDEADBEEF to reg 5 -> rdata_a=rdata_b=0 and rvalid=0 immediately. After release, a read of reg 5 returns 0.
- Basic write/read:
  - Write 0x12345678 to reg 7 with wbe=4'hF.
  - Read A=7, B=7 the next cycle -> both rdata=0x12345678 one cycle later, rvalid_a=rvalid_b=1.
- Byte enables: reg 3 holds 0xAABBCCDD; write 0x11223344 with wbe=4'b0101 -> reg 3 reads 0xAA22CC44.
- Forwarding: reg 9 holds 0x0; in one cycle write 0xCAFEF00D to reg 9 (wbe=4'hF) and read A=9 -> rdata_a=0xCAFEF00D next cycle. Repeat with wbe=4'b0011 -> 0x0000F00D.
- Out-of-range and hold (DEPTH=24):
  - Write to addr 30 -> no register changes.
  - Read addr 30 -> rdata=0, rvalid=1.
  - Then re_a=0 for 3 cycles -> rdata_a held, rvalid_a=0.
- Zero register:
  - With REGFILE_ZERO_REG_EN: write 0xFFFFFFFF to reg 0 while reading reg 0 -> rdata=0.
  - Without the macro: same stimulus gives rdata=0xFFFFFFFF.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered reads, byte enables and write-to-read forwarding.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero (no storage, writes and forwarding dropped).
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic                  re_a,
  input  logic [ADDR_W-1:0]     raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  output logic                  rvalid_a,
  input  logic                  re_b,
  input  logic [ADDR_W-1:0]     raddr_b,
  output logic [DATA_W-1:0]     rdata_b,
  output logic                  rvalid_b
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned DEPTH_U = DEPTH;
`ifdef REGFILE_ZERO_REG_EN
  localparam int unsigned FIRST_REG = 1;
`else
  localparam int unsigned FIRST_REG = 0;
`endif

  logic [DEPTH-1:0][DATA_W-1:0] words;
  logic [DATA_W-1:0]            rd_next_a;
  logic [DATA_W-1:0]            rd_next_b;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [NB-1:0]     be);
    logic [DATA_W-1:0] r;
    r = old_word;
    for (int i = 0; i < int'(NB); i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

  // Word 0 has no flops when it is hardwired to zero.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_word
      if (g < FIRST_REG) begin : g_zero
        assign words[g] = '0;
      end else begin : g_reg
        logic [DATA_W-1:0] q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            q <= '0;
          end else if (we && (waddr == ADDR_W'(g))) begin
            q <= merge_bytes(q, wdata, wbe);
          end
        end
        assign words[g] = q;
      end
    end
  endgenerate

  // Returns the post-write view of a word: out of range reads as zero, a same-cycle write forwards.
  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] r;
    r = '0;
    if (32'(ra) < DEPTH_U) begin
      r = words[ra];
      if (we && (waddr == ra) && (32'(ra) >= FIRST_REG)) r = merge_bytes(r, wdata, wbe);
    end
    return r;
  endfunction

  always_comb begin
    rd_next_a = read_word(raddr_a);
    rd_next_b = read_word(raddr_b);
  end

  // rvalid_x is a one-cycle strobe meaning rdata_x was loaded at the last edge; there is no
  // backpressure, so a read issued with re_x=1 always returns exactly one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a  <= '0;
      rvalid_a <= 1'b0;
      rdata_b  <= '0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= re_a;
      rvalid_b <= re_b;
      if (re_a) rdata_a <= rd_next_a;
      if (re_b) rdata_b <= rd_next_b;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomized scoreboard bench for regfile_2r1w (DEPTH=24 so out-of-range addresses are reachable).
module tb_regfile_2r1w;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 24;
  localparam int ADDR_W = 5;
  localparam int NB     = DATA_W / 8;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [NB-1:0]     wbe;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic              rvalid_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rvalid_b;

  regfile_2r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // reference model: register contents as plain words
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_qa [$];
  logic [DATA_W-1:0] exp_qb [$];

  function automatic bool_is_zero_reg(input int addr);
`ifdef REGFILE_ZERO_REG_EN
    return addr == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // driver: present one cycle of stimulus starting just after a falling edge
  task automatic step(input logic w, input int wa, input logic [DATA_W-1:0] wd, input logic [NB-1:0] be,
                      input logic ra_en, input int ra, input logic rb_en, input int rb);
    logic [DATA_W-1:0] after_mem [DEPTH];
    logic [DATA_W-1:0] ea, eb;
    we = w; waddr = ADDR_W'(wa); wdata = wd; wbe = be;
    re_a = ra_en; raddr_a = ADDR_W'(ra); re_b = rb_en; raddr_b = ADDR_W'(rb);
    // contents the register file holds once this cycle's write has landed
    for (int i = 0; i < DEPTH; i++) after_mem[i] = model_mem[i];
    if (w && wa < DEPTH && !bool_is_zero_reg(wa))
      for (int i = 0; i < NB; i++) if (be[i]) after_mem[wa][8*i +: 8] = wd[8*i +: 8];
    ea = (ra < DEPTH) ? after_mem[ra] : '0;
    eb = (rb < DEPTH) ? after_mem[rb] : '0;
    @(posedge clk);
    if (ra_en) exp_qa.push_back(ea);
    if (rb_en) exp_qb.push_back(eb);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = after_mem[i];
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, '0, '0, 1'b0, 0, 1'b0, 0);
  endtask

  // monitor: pops expected data whenever a port presents rvalid
  logic [DATA_W-1:0] last_a = '0;
  logic [DATA_W-1:0] last_b = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("reset_rdata_a", rdata_a, '0);
        check("reset_rvalid_a", {31'd0, rvalid_a}, '0);
        last_a = '0;
        last_b = '0;
      end else begin
        if (rvalid_a) begin
          if (exp_qa.size() == 0) check("spurious_rvalid_a", {31'd0, rvalid_a}, '0);
          else begin last_a = exp_qa.pop_front(); check("rdata_a", rdata_a, last_a); end
        end else begin
          check("hold_rdata_a", rdata_a, last_a);
          if (exp_qa.size() != 0) begin check("missing_rvalid_a", {31'd0, rvalid_a}, 1); exp_qa.delete(); end
        end
        if (rvalid_b) begin
          if (exp_qb.size() == 0) check("spurious_rvalid_b", {31'd0, rvalid_b}, '0);
          else begin last_b = exp_qb.pop_front(); check("rdata_b", rdata_b, last_b); end
        end else begin
          check("hold_rdata_b", rdata_b, last_b);
          if (exp_qb.size() != 0) begin check("missing_rvalid_b", {31'd0, rvalid_b}, 1); exp_qb.delete(); end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    we = 0; waddr = '0; wdata = '0; wbe = '0;
    re_a = 0; raddr_a = '0; re_b = 0; raddr_b = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset mid-operation clears storage and outputs without waiting for a clock
    step(1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b0, 0, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 5, 1'b1, 5);
    #2;
    rst_n = 1'b0;
    exp_qa.delete(); exp_qb.delete();
    model_clear();
    #1;
    check("async_reset_rdata_a", rdata_a, '0);
    check("async_reset_rdata_b", rdata_b, '0);
    check("async_reset_rvalid", {30'd0, rvalid_a, rvalid_b}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 0, '0, '0, 1'b1, 5, 1'b1, 5);

    // basic write then dual read of the same address
    step(1'b1, 7, 32'h12345678, 4'hF, 1'b0, 0, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 7, 1'b1, 7);

    // byte enables
    step(1'b1, 3, 32'hAABBCCDD, 4'hF, 1'b0, 0, 1'b0, 0);
    step(1'b1, 3, 32'h11223344, 4'b0101, 1'b0, 0, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 3, 1'b1, 3);

    // forwarding, full and partial
    step(1'b1, 9, 32'hCAFEF00D, 4'hF, 1'b1, 9, 1'b0, 0);
    step(1'b1, 9, 32'h00000000, 4'hF, 1'b0, 0, 1'b0, 0);
    step(1'b1, 9, 32'hCAFEF00D, 4'b0011, 1'b1, 9, 1'b1, 9);
    step(1'b1, 9, 32'h5A5A5A5A, 4'b0000, 1'b1, 9, 1'b0, 0);

    // out of range write and read, then hold
    step(1'b1, 30, 32'hFFFFFFFF, 4'hF, 1'b1, 30, 1'b1, 7);
    idle(3);
    for (int i = 0; i < DEPTH; i += 2) step(1'b0, 0, '0, '0, 1'b1, i, 1'b1, i + 1);

    // register 0: written and read in the same cycle, then read back
    step(1'b1, 0, 32'hFFFFFFFF, 4'hF, 1'b1, 0, 1'b1, 0);
    step(1'b0, 0, '0, '0, 1'b1, 0, 1'b0, 0);

    // random traffic, addresses span the out-of-range region
    for (int k = 0; k < 600; k++) begin
      int wa, ra, rb;
      wa = $urandom_range(0, 31);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      rb = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      step(1'($urandom_range(0, 1)), wa, $urandom, NB'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), ra, 1'($urandom_range(0, 3) != 0), rb);
    end
    idle(2);
    check("queue_a_drained", 32'(exp_qa.size()), '0);
    check("queue_b_drained", 32'(exp_qb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
